// File: rtl/bullet_collider_pkg.sv
// Shared game definitions for the bullet collider.
// Bullet colour codes, FSM state codes, hit-point default and the per-kind hp delta.
package bullet_collider_pkg;

    localparam int HP_MAX_DEFAULT = 20;

    localparam logic [1:0] COLOR_WHITE = 2'b00;
    localparam logic [1:0] COLOR_GREEN = 2'b01;
    localparam logic [1:0] COLOR_BLUE  = 2'b10;
    localparam logic [1:0] COLOR_RSVD  = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // hp change a landed bullet of this kind contributes
    function automatic logic signed [5:0] hit_delta(input logic [1:0] color);
        logic signed [5:0] d;
        d = 6'sd0;
        unique case (color)
            COLOR_WHITE: d = -6'sd1;
            COLOR_GREEN: d = 6'sd1;
            COLOR_BLUE:  d = -6'sd1;
            COLOR_RSVD:  d = 6'sd0;
            default:     d = 6'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bullet_collider_box_overlap.sv
// Combinational axis-aligned box overlap test using 9-bit edge sums.
// Ports: pos_a/size_a, pos_b/size_b ({x,y} / {w,h}); hit = boxes overlap.
module box_overlap (
    input  logic [15:0] pos_a,
    input  logic [15:0] size_a,
    input  logic [15:0] pos_b,
    input  logic [15:0] size_b,
    output logic        hit
);

    logic [8:0] ax, ay, bx, by;
    logic [8:0] ax_end, ay_end, bx_end, by_end;
    logic       empty;

    // 9-bit right/bottom edges so boxes near 255 do not wrap
    assign ax     = {1'b0, pos_a[15:8]};
    assign ay     = {1'b0, pos_a[7:0]};
    assign bx     = {1'b0, pos_b[15:8]};
    assign by     = {1'b0, pos_b[7:0]};
    assign ax_end = ax + {1'b0, size_a[15:8]};
    assign ay_end = ay + {1'b0, size_a[7:0]};
    assign bx_end = bx + {1'b0, size_b[15:8]};
    assign by_end = by + {1'b0, size_b[7:0]};

    assign empty = (size_a[15:8] == 8'd0) || (size_a[7:0] == 8'd0)
                || (size_b[15:8] == 8'd0) || (size_b[7:0] == 8'd0);

    assign hit = !empty
              && (bx < ax_end) && (ax < bx_end)
              && (by < ay_end) && (ay < by_end);

endmodule

// File: rtl/bullet_collider.sv
// Per-frame scan of bullet slots against the player box, updating hit points.
// Ports: clk/reset, isRun/frameTick, player box, bullet store port, indexCollide/isComplete/hp/gameOver.
module bullet_collider
    import bullet_collider_pkg::*;
#(
    parameter int NUM_BULLETS = 3,
    parameter int HP_MAX      = HP_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        isRun,
    input  logic        frameTick,
    input  logic [15:0] playerPosition,
    input  logic [15:0] playerSize,
    input  logic        playerMoving,
    output logic [2:0]  index2,
    input  logic [15:0] position2,
    input  logic [15:0] size2,
    input  logic [1:0]  color2,
    input  logic        isRender2,
    output logic [2:0]  indexCollide,
    output logic        isComplete,
    output logic [7:0]  hp,
    output logic        gameOver
);

    logic [2:0]         state;
    logic [15:0]        cap_pos;
    logic [15:0]        cap_size;
    logic [1:0]         cap_color;
    logic               cap_render;
    logic [2:0]         hit_mask;
    logic signed [5:0]  delta;

    logic               overlap;
    logic               kind_hit;
    logic               slot_hit;
    logic signed [5:0]  slot_delta;
    logic [2:0]         bit_sel;
    logic signed [9:0]  hp_sum;
    logic [7:0]         hp_next;

    box_overlap u_overlap (
        .pos_a  (playerPosition),
        .size_a (playerSize),
        .pos_b  (cap_pos),
        .size_b (cap_size),
        .hit    (overlap)
    );

    always_comb begin
        kind_hit = 1'b0;
        unique case (cap_color)
            COLOR_WHITE: kind_hit = 1'b1;
            COLOR_GREEN: kind_hit = 1'b1;
            COLOR_BLUE:  kind_hit = playerMoving;
            default:     kind_hit = 1'b0;
        endcase
        slot_hit   = cap_render && overlap && kind_hit;
        slot_delta = slot_hit ? hit_delta(cap_color) : 6'sd0;
        // slots beyond the 3-bit mask simply drop out
        bit_sel    = 3'b001 << index2;
    end

    // whole-scan delta applied at once, then clamped
    always_comb begin
        hp_sum = $signed({2'b00, hp}) + 10'(delta);
        if (hp_sum < 10'sd0) begin
            hp_next = 8'd0;
        end else if (hp_sum > 10'(HP_MAX)) begin
            hp_next = 8'(HP_MAX);
        end else begin
            hp_next = hp_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            index2       <= 3'd0;
            cap_pos      <= 16'd0;
            cap_size     <= 16'd0;
            cap_color    <= 2'd0;
            cap_render   <= 1'b0;
            hit_mask     <= 3'd0;
            delta        <= 6'sd0;
            indexCollide <= 3'b111;
            isComplete   <= 1'b0;
            hp           <= 8'(HP_MAX);
            gameOver     <= 1'b0;
        end else begin
            isComplete <= 1'b0;
            if (state != ST_IDLE && !isRun) begin
                // abort: partial results are dropped on the next start
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frameTick && isRun && !gameOver) begin
                            state    <= ST_ADDR;
                            index2   <= 3'd0;
                            hit_mask <= 3'd0;
                            delta    <= 6'sd0;
                        end
                    end
                    ST_ADDR: begin
                        state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        cap_pos    <= position2;
                        cap_size   <= size2;
                        cap_color  <= color2;
                        cap_render <= isRender2;
                        state      <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (slot_hit) begin
                            hit_mask <= hit_mask | bit_sel;
                        end
                        delta <= delta + slot_delta;
                        if (int'(index2) < NUM_BULLETS - 1) begin
                            index2 <= index2 + 3'd1;
                            state  <= ST_ADDR;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        hp           <= hp_next;
                        gameOver     <= (hp_next == 8'd0);
                        indexCollide <= ~hit_mask;
                        isComplete   <= 1'b1;
                        state        <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bullet_collider.sv
// Randomised and directed bench for bullet_collider against a frame-level model.
// Compares isComplete/hp/indexCollide/gameOver every cycle, plus literal pins.
module tb_bullet_collider;

    logic        clk;
    logic        reset;
    logic        isRun;
    logic        frameTick;
    logic [15:0] playerPosition;
    logic [15:0] playerSize;
    logic        playerMoving;
    logic [2:0]  index2;
    logic [15:0] position2;
    logic [15:0] size2;
    logic [1:0]  color2;
    logic        isRender2;
    logic [2:0]  indexCollide;
    logic        isComplete;
    logic [7:0]  hp;
    logic        gameOver;

    logic [7:0] bx [8];
    logic [7:0] by [8];
    logic [7:0] bw [8];
    logic [7:0] bh [8];
    logic [1:0] bc [8];
    logic       br [8];

    assign position2 = {bx[index2], by[index2]};
    assign size2     = {bw[index2], bh[index2]};
    assign color2    = bc[index2];
    assign isRender2 = br[index2];

    bullet_collider dut (
        .clk            (clk),
        .reset          (reset),
        .isRun          (isRun),
        .frameTick      (frameTick),
        .playerPosition (playerPosition),
        .playerSize     (playerSize),
        .playerMoving   (playerMoving),
        .index2         (index2),
        .position2      (position2),
        .size2          (size2),
        .color2         (color2),
        .isRender2      (isRender2),
        .indexCollide   (indexCollide),
        .isComplete     (isComplete),
        .hp             (hp),
        .gameOver       (gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // frame-level model
    logic       m_active;
    int         m_k;
    int         m_hp;
    logic [2:0] m_mask;
    logic       m_go;
    logic       m_cmp;
    int         pend_hp;
    logic [2:0] pend_mask;

    function automatic bit ovl(int ax, int ay, int aw, int ah,
                               int cx, int cy, int cw, int ch);
        if (aw == 0 || ah == 0 || cw == 0 || ch == 0) return 1'b0;
        return (cx < ax + aw) && (ax < cx + cw) && (cy < ay + ah) && (ay < cy + ch);
    endfunction

    function automatic int model_hp(int hp0, logic mv);
        int d;
        int n;
        d = 0;
        for (int i = 0; i < 3; i++) begin
            if (br[i] && ovl(int'(playerPosition[15:8]), int'(playerPosition[7:0]),
                             int'(playerSize[15:8]), int'(playerSize[7:0]),
                             int'(bx[i]), int'(by[i]), int'(bw[i]), int'(bh[i]))) begin
                if (bc[i] == 2'd0) d = d - 1;
                if (bc[i] == 2'd1) d = d + 1;
                if (bc[i] == 2'd2 && mv) d = d - 1;
            end
        end
        n = hp0 + d;
        if (n < 0) n = 0;
        if (n > 20) n = 20;
        return n;
    endfunction

    function automatic logic [2:0] model_mask(logic mv);
        logic [2:0] m;
        m = 3'b111;
        for (int i = 0; i < 3; i++) begin
            if (br[i] && ovl(int'(playerPosition[15:8]), int'(playerPosition[7:0]),
                             int'(playerSize[15:8]), int'(playerSize[7:0]),
                             int'(bx[i]), int'(by[i]), int'(bw[i]), int'(bh[i]))) begin
                if (bc[i] == 2'd0 || bc[i] == 2'd1 || (bc[i] == 2'd2 && mv)) m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    always @(posedge clk) begin
        m_cmp <= 1'b0;
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_hp     <= 20;
            m_mask   <= 3'b111;
            m_go     <= 1'b0;
        end else if (m_active) begin
            if (!isRun) begin
                m_active <= 1'b0;
            end else if (m_k == 9) begin
                m_active <= 1'b0;
                m_hp     <= pend_hp;
                m_mask   <= pend_mask;
                m_go     <= (pend_hp == 0);
                m_cmp    <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (frameTick && isRun && !m_go) begin
            m_active  <= 1'b1;
            m_k       <= 0;
            pend_hp   <= model_hp(m_hp, playerMoving);
            pend_mask <= model_mask(playerMoving);
        end
    end

    // literal pins, posted by the stimulus process
    logic       lit_valid;
    int         lit_hp;
    logic [2:0] lit_mask;
    logic       lit_go;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("isComplete", int'(isComplete), int'(m_cmp));
            chk("hp", int'(hp), m_hp);
            chk("indexCollide", int'(indexCollide), int'(m_mask));
            chk("gameOver", int'(gameOver), int'(m_go));
            if (lit_valid) begin
                chk("lit_hp", int'(hp), lit_hp);
                chk("lit_mask", int'(indexCollide), int'(lit_mask));
                chk("lit_gameOver", int'(gameOver), int'(lit_go));
            end
        end
    end

    task automatic lit(int h, logic [2:0] m, logic g);
        lit_hp    = h;
        lit_mask  = m;
        lit_go    = g;
        lit_valid = 1'b1;
        @(negedge clk);
        #1 lit_valid = 1'b0;
    endtask

    task automatic clear_bullets();
        for (int i = 0; i < 8; i++) begin
            bx[i] = 8'd0; by[i] = 8'd0; bw[i] = 8'd4; bh[i] = 8'd4;
            bc[i] = 2'd0; br[i] = 1'b0;
        end
    endtask

    task automatic set_b(int i, int x, int y, int w, int h, int c, bit r);
        bx[i] = 8'(x); by[i] = 8'(y); bw[i] = 8'(w); bh[i] = 8'(h);
        bc[i] = 2'(c); br[i] = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic scan();
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        isRun          = 1'b1;
        frameTick      = 1'b0;
        playerPosition = {8'd100, 8'd100};
        playerSize     = {8'd16, 8'd16};
        playerMoving   = 1'b0;
        lit_valid      = 1'b0;
        lit_hp         = 0;
        lit_mask       = 3'b000;
        lit_go         = 1'b0;
        clear_bullets();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lit(20, 3'b111, 1'b0);

        // single white hit
        set_b(0, 108, 108, 16, 16, 0, 1'b1);
        set_b(1, 0, 0, 4, 4, 0, 1'b1);
        set_b(2, 0, 0, 4, 4, 0, 1'b1);
        scan();
        lit(19, 3'b110, 1'b0);

        // blue: needs movement
        clear_bullets();
        set_b(1, 104, 104, 8, 8, 2, 1'b1);
        scan();
        lit(19, 3'b111, 1'b0);
        playerMoving = 1'b1;
        scan();
        lit(18, 3'b101, 1'b0);
        playerMoving = 1'b0;

        // edge touch, no wrap near 255, zero width
        clear_bullets();
        set_b(0, 116, 100, 8, 8, 0, 1'b1);
        scan();
        lit(18, 3'b111, 1'b0);
        playerPosition = {8'd250, 8'd250};
        playerSize     = {8'd10, 8'd10};
        clear_bullets();
        set_b(2, 255, 255, 4, 4, 0, 1'b1);
        scan();
        lit(17, 3'b011, 1'b0);
        clear_bullets();
        set_b(0, 252, 252, 0, 4, 0, 1'b1);
        scan();
        lit(17, 3'b111, 1'b0);

        // green saturates at the ceiling
        do_reset();
        clear_bullets();
        set_b(0, 252, 252, 4, 4, 1, 1'b1);
        scan();
        lit(20, 3'b110, 1'b0);

        // drain to 1, then two whites + green -> 0
        clear_bullets();
        for (int i = 0; i < 3; i++) set_b(i, 251, 251, 4, 4, 0, 1'b1);
        repeat (6) scan();
        lit(2, 3'b000, 1'b0);
        br[1] = 1'b0; br[2] = 1'b0;
        scan();
        lit(1, 3'b110, 1'b0);
        br[1] = 1'b1; br[2] = 1'b1; bc[2] = 2'd1;
        scan();
        lit(0, 3'b000, 1'b1);
        scan();
        lit(0, 3'b000, 1'b1);

        // abort via isRun, then reset mid-scan
        do_reset();
        clear_bullets();
        set_b(0, 251, 251, 4, 4, 0, 1'b1);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (4) @(negedge clk);
        isRun = 1'b0;
        repeat (3) @(negedge clk);
        isRun = 1'b1;
        repeat (12) @(negedge clk);
        lit(20, 3'b111, 1'b0);
        scan();
        lit(19, 3'b110, 1'b0);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (12) @(negedge clk);
        lit(20, 3'b111, 1'b0);

        // repeated frameTick inside a scan is ignored
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (3) @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (2) @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        repeat (8) @(negedge clk);
        lit(19, 3'b110, 1'b0);

        // random trials
        for (int t = 0; t < 300; t++) begin
            playerPosition = 16'($urandom);
            playerSize     = {8'($urandom_range(0, 24)), 8'($urandom_range(0, 24))};
            playerMoving   = 1'($urandom_range(0, 1));
            for (int i = 0; i < 3; i++) begin
                set_b(i,
                      int'(playerPosition[15:8]) + int'($urandom_range(0, 40)) - 20,
                      int'(playerPosition[7:0]) + int'($urandom_range(0, 40)) - 20,
                      int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            end
            if (m_go) begin
                do_reset();
            end
            for (int c = 0; c < 14; c++) begin
                frameTick = ($urandom_range(0, 3) == 0);
                isRun     = ($urandom_range(0, 15) != 0);
                reset     = ($urandom_range(0, 199) == 0);
                @(negedge clk);
            end
            frameTick = 1'b0;
            isRun     = 1'b1;
            reset     = 1'b0;
            for (int w = 0; w < 20 && m_active; w++) @(negedge clk);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bullet_collider.md
BULLET_COLLIDER -- requirements
Module: bullet_collider

Interface
REQ-001 Parameter NUM_BULLETS, default 3, number of bullet slots scanned (indices 0..NUM_BULLETS-1).
REQ-002 Parameter HP_MAX, default 20, player hit-point ceiling and reset value.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 isRun  input  1  game-running qualifier; scans start only while high.
REQ-006 frameTick  input  1  one-cycle pulse requesting a new scan.
REQ-007 playerPosition  input  16  heart box origin, x [15:8], y [7:0].
REQ-008 playerSize  input  16  heart box size, w [15:8], h [7:0].
REQ-009 playerMoving  input  1  heart moved since last frame.
REQ-010 index2  output  3  bullet slot address driven to the bullet store's collision port.
REQ-011 position2  input  16  addressed bullet origin, x [15:8], y [7:0], combinational from index2.
REQ-012 size2  input  16  addressed bullet size, w [15:8], h [7:0].
REQ-013 color2  input  2  bullet kind: 00 white, 01 green, 10 blue, 11 reserved.
REQ-014 isRender2  input  1  bullet slot active.
REQ-015 indexCollide  output  3  per-slot render-keep mask, bit i = 0 when slot i was hit in the last scan.
REQ-016 isComplete  output  1  one-cycle pulse when a scan finishes and indexCollide is valid.
REQ-017 hp  output  8  current player hit points.
REQ-018 gameOver  output  1  high while hp == 0.

Function
REQ-019 FSM states: IDLE, ADDR, CAPTURE, CHECK, DONE.
REQ-020 IDLE -> ADDR when frameTick && isRun && !gameOver; index2 set to 0 and the hit accumulator cleared on that edge.
REQ-021 ADDR lasts 1 cycle, with index2 stable; CAPTURE registers position2, size2, color2 and isRender2; CHECK evaluates the registered bullet.
REQ-022 From CHECK, go to ADDR with index2+1 if index2 < NUM_BULLETS-1, else go to DONE.
REQ-023 Scan latency: exactly 3*NUM_BULLETS+1 cycles from the frameTick edge to the isComplete pulse (10 cycles at default).
REQ-024 Overlap test uses 9-bit unsigned sums, hit when bx < px+pw && px < bx+bw && by < py+ph && py < by+bh; there is no 8-bit wrap-around.
REQ-025 A zero-width or zero-height box never overlaps anything.
REQ-026 A slot counts as a hit only if isRender2 is captured high and overlap is true.
REQ-027 Hit effect by kind: white gives -1 hp; blue gives -1 hp only if playerMoving is sampled in CHECK; green gives +1 hp; reserved gives no effect and is not a hit.
REQ-028 Per-scan hp update is applied in DONE as a single signed sum, saturated to [0, HP_MAX].
REQ-029 In DONE, indexCollide <= ~hitMask (bits above NUM_BULLETS-1 are 1), isComplete is pulsed for 1 cycle, and the FSM returns to IDLE.
REQ-030 indexCollide holds its value between scans.
REQ-031 frameTick arriving outside IDLE is ignored, with no queueing.
REQ-032 isRun falling mid-scan aborts the scan at the next edge: go to IDLE, no hp change, no isComplete, indexCollide unchanged.
REQ-033 gameOver = (hp == 0), registered with hp; no scans are started while gameOver is high.

Reset
REQ-034 On reset: state IDLE, index2 = 0, indexCollide = 3'b111, isComplete = 0, hp = HP_MAX, gameOver = 0, and captured bullet registers cleared.
REQ-035 Reset mid-scan discards all partial results at that edge.

Structure
REQ-036 A shared game package holds the bullet colour encodings, the FSM state encoding, and the HP_MAX default.
REQ-037 One sub-module, box_overlap, is the purely combinational 9-bit AABB test of REQ-024/025.

Verification
REQ-038 Player (100,100,16,16), slot0 white at (108,108,16,16) rendered, others off-screen, frameTick -> isComplete 10 cycles later, indexCollide=3'b110, hp 20->19.
REQ-039 Blue bullet overlapping with playerMoving=0 -> no hp change, indexCollide=3'b111; same with playerMoving=1 -> hp -1, bit cleared.
REQ-040 Edge-touch: bullet x=116 with player x=100 w=16 -> no hit; player (250,250,10,10) with bullet at (255,255,4,4) -> hit, no wrap artefact.
REQ-041 hp=1, two white hits plus one green hit in one scan -> hp=0, gameOver=1, and a subsequent frameTick starts no scan.
REQ-042 isRun dropped at cycle 5 of a scan -> no isComplete, hp and indexCollide unchanged; reset asserted mid-scan -> hp=20, indexCollide=3'b111.
REQ-043 frameTick repeated during a scan -> exactly one isComplete per started scan.
